// File: rtl/spi_slave_with_cs_if.sv
// Bundle of the byte-stream handshake and SPI pin signals of the SPI peripheral endpoint.
interface spi_slave_with_cs_if;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Ready;
    logic       o_TX_Underrun;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_CS_Active;
    logic       i_SPI_Clk;
    logic       i_SPI_CS_n;
    logic       i_SPI_MOSI;
    logic       o_SPI_MISO;
    logic       o_SPI_MISO_En;

    modport slave (
        input  i_TX_DV, i_TX_Byte, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
        output o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_CS_Active,
               o_SPI_MISO, o_SPI_MISO_En
    );

    modport master (
        output i_TX_DV, i_TX_Byte, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
        input  o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_CS_Active,
               o_SPI_MISO, o_SPI_MISO_En
    );
endinterface

// File: rtl/spi_slave_with_cs.sv
// Oversampled SPI peripheral endpoint: all four modes, MSB first, 8-bit frames,
// received byte stream out and a one-deep TX holding register in.
module spi_slave_with_cs #(
    parameter int unsigned SPI_MODE    = 0,
    parameter logic [7:0]  DEFAULT_TX  = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                i_Clk,
    input logic                i_Rst_L,
    spi_slave_with_cs_if.slave bus
);

    localparam logic [1:0]  MODE_BITS = 2'(SPI_MODE);
    localparam logic        CPOL      = MODE_BITS[1];
    localparam logic        CPHA      = MODE_BITS[0];
    localparam int unsigned SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_N-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_N-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_N-1:0] mosi_sync_q, mosi_sync_d;
    logic              sclk_dly_q, sclk_dly_d;
    logic              cs_dly_q, cs_dly_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       rx_dv_q, rx_dv_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       underrun_q, underrun_d;

    logic sclk_s, cs_n_s, mosi_s;
    logic clk_rise_s, clk_fall_s, leading_s, trailing_s, sample_s, shift_s;
    logic cs_fall_s, cs_rise_s, load_s;

    // Synchronizer chains shift the raw pins in; delay flops remember the last synced level.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_N-2:0], bus.i_SPI_Clk};
        cs_sync_d   = {cs_sync_q[SYNC_N-2:0], bus.i_SPI_CS_n};
        mosi_sync_d = {mosi_sync_q[SYNC_N-2:0], bus.i_SPI_MOSI};
        sclk_dly_d  = sclk_sync_q[SYNC_N-1];
        cs_dly_d    = cs_sync_q[SYNC_N-1];
    end

    // Synchronizer and edge-detect registers, cleared to the idle pin levels.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync_q <= {SYNC_N{CPOL}};
            cs_sync_q   <= {SYNC_N{1'b1}};
            mosi_sync_q <= {SYNC_N{1'b0}};
            sclk_dly_q  <= CPOL;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
        end
    end

    assign sclk_s     = sclk_sync_q[SYNC_N-1];
    assign cs_n_s     = cs_sync_q[SYNC_N-1];
    assign mosi_s     = mosi_sync_q[SYNC_N-1];
    assign clk_rise_s = sclk_s & ~sclk_dly_q;
    assign clk_fall_s = ~sclk_s & sclk_dly_q;
    assign cs_fall_s  = ~cs_n_s & cs_dly_q;
    assign cs_rise_s  = cs_n_s & ~cs_dly_q;
    assign leading_s  = CPOL ? clk_fall_s : clk_rise_s;
    assign trailing_s = CPOL ? clk_rise_s : clk_fall_s;
    assign sample_s   = CPHA ? trailing_s : leading_s;
    assign shift_s    = CPHA ? leading_s : trailing_s;

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the synchronized chip select alone opens and closes a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = cs_fall_s ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_d = cs_rise_s ? ST_IDLE : ST_ACTIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: shift engines, byte loads and the TX holding-register handshake.
    always_comb begin
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        underrun_d  = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    bit_cnt_d = 3'd0;
                    load_s    = ~CPHA;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_ACTIVE: begin
                // A CS edge wins over any clock edge seen in the same cycle.
                if (cs_rise_s) begin
                    bit_cnt_d = 3'd0;
                end else if (sample_s) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_dv_d   = 1'b1;
                        rx_byte_d = {rx_shift_q, mosi_s};
                    end else begin
                        rx_dv_d = 1'b0;
                    end
                end else if (shift_s) begin
                    if (bit_cnt_q == 3'd0) begin
                        load_s = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            default: begin
                bit_cnt_d = 3'd0;
            end
        endcase

        if (load_s) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = DEFAULT_TX;
                underrun_d = 1'b1;
            end
        end else begin
            underrun_d = 1'b0;
        end

        // Gated on the pre-load fullness, so a write racing an underrun load is still captured.
        if (bus.i_TX_DV && !hold_full_q) begin
            hold_d      = bus.i_TX_Byte;
            hold_full_d = 1'b1;
        end else begin
            hold_d = (hold_full_d) ? hold_q : hold_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= DEFAULT_TX;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= 8'd0;
            underrun_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.o_TX_Ready    = ~hold_full_q;
    assign bus.o_TX_Underrun = underrun_q;
    assign bus.o_RX_DV       = rx_dv_q;
    assign bus.o_RX_Byte     = rx_byte_q;
    assign bus.o_CS_Active   = (state_q == ST_ACTIVE);
    assign bus.o_SPI_MISO_En = (state_q == ST_ACTIVE);
    assign bus.o_SPI_MISO    = tx_shift_q[7];

endmodule

// File: tb/tb_spi_slave_with_cs.sv
// Directed bench for spi_slave_with_cs: one instance per SPI mode, a bit-banged
// master, and a scoreboard queue of the bytes the slave should deliver.
module tb_spi_slave_with_cs;

    logic i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    logic       i_Rst_L;
    logic [3:0] sclk_s, csn_s, tx_dv_s;
    logic       mosi_s;
    logic [7:0] tx_byte_s;
    logic [3:0] rx_dv_w, und_w, ready_w, cs_w, miso_w, misoen_w;
    logic [7:0] rx_byte_w [4];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_with_cs_if bus ();
        assign bus.i_TX_DV    = tx_dv_s[g];
        assign bus.i_TX_Byte  = tx_byte_s;
        assign bus.i_SPI_Clk  = sclk_s[g];
        assign bus.i_SPI_CS_n = csn_s[g];
        assign bus.i_SPI_MOSI = mosi_s;
        assign rx_dv_w[g]     = bus.o_RX_DV;
        assign rx_byte_w[g]   = bus.o_RX_Byte;
        assign und_w[g]       = bus.o_TX_Underrun;
        assign ready_w[g]     = bus.o_TX_Ready;
        assign cs_w[g]        = bus.o_CS_Active;
        assign miso_w[g]      = bus.o_SPI_MISO;
        assign misoen_w[g]    = bus.o_SPI_MISO_En;
        spi_slave_with_cs #(.SPI_MODE(g), .DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) u_dut (
            .i_Clk  (i_Clk),
            .i_Rst_L(i_Rst_L),
            .bus    (bus)
        );
    end

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] rx_exp_q [$];
    logic [7:0] pend_byte;
    logic       pend_valid;
    int         rx_cnt [4];
    int         und_cnt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One system-clock step: monitors the DUT and issues any pending holding-register write.
    task automatic tick(input int m);
        logic [7:0] exp_b;
        @(negedge i_Clk);
        tx_dv_s[m] = 1'b0;
        if (rx_dv_w[m]) begin
            rx_cnt[m]++;
            vectors++;
            assert (rx_exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL rx_unexpected: observed %0h expected no byte", rx_byte_w[m]);
            end
            if (rx_exp_q.size() != 0) begin
                exp_b = rx_exp_q.pop_front();
                check("rx_byte", {24'd0, rx_byte_w[m]}, {24'd0, exp_b});
            end
        end
        if (und_w[m]) und_cnt[m]++;
        if (pend_valid && ready_w[m]) begin
            tx_byte_s  = pend_byte;
            tx_dv_s[m] = 1'b1;
            pend_valid = 1'b0;
        end
    endtask

    task automatic half(input int m);
        repeat (8) tick(m);
    endtask

    task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        rx = 8'h00;
        if (nbits == 8) rx_exp_q.push_back(tx);
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi_s = tx[i];
                half(m);
                rx[i] = miso_w[m];
                sclk_s[m] = ~cpol;
                half(m);
                sclk_s[m] = cpol;
            end else begin
                sclk_s[m] = ~cpol;
                mosi_s = tx[i];
                half(m);
                rx[i] = miso_w[m];
                sclk_s[m] = cpol;
                half(m);
            end
        end
    endtask

    task automatic cs_low(input int m);
        csn_s[m] = 1'b0;
        half(m);
        check("cs_active", {31'd0, cs_w[m]}, 32'd1);
        check("miso_en", {31'd0, misoen_w[m]}, 32'd1);
    endtask

    task automatic cs_high(input int m);
        half(m);
        csn_s[m] = 1'b1;
        half(m);
        half(m);
    endtask

    task automatic write_hold(input int m, input logic [7:0] b);
        pend_byte  = b;
        pend_valid = 1'b1;
        for (int k = 0; k < 40 && pend_valid; k++) tick(m);
        tick(m);
        check("wr_accept", {31'd0, pend_valid}, 32'd0);
        check("ready_low", {31'd0, ready_w[m]}, 32'd0);
    endtask

    initial begin
        logic [7:0] r0, r1;
        int         base_rx, base_und;
        i_Rst_L    = 1'b0;
        sclk_s     = 4'b1100;
        csn_s      = 4'hF;
        tx_dv_s    = 4'h0;
        mosi_s     = 1'b0;
        tx_byte_s  = 8'h00;
        pend_byte  = 8'h00;
        pend_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_cnt[i]  = 0;
            und_cnt[i] = 0;
        end
        repeat (4) @(negedge i_Clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", {31'd0, ready_w[i]}, 32'd1);
            check("rst_miso", {31'd0, miso_w[i]}, 32'd1);
        end
        check("rst_rx_dv", {31'd0, rx_dv_w[0]}, 32'd0);
        check("rst_rx_byte", {24'd0, rx_byte_w[0]}, 32'd0);
        check("rst_underrun", {31'd0, und_w[0]}, 32'd0);
        check("rst_cs_active", {31'd0, cs_w[0]}, 32'd0);
        check("rst_miso_en", {31'd0, misoen_w[0]}, 32'd0);
        i_Rst_L = 1'b1;
        repeat (4) tick(0);

        // Mode 0: preloaded byte goes out, master byte comes in.
        base_rx = rx_cnt[0];
        write_hold(0, 8'h3C);
        cs_low(0);
        xfer(0, 8'hA5, 8, r0);
        cs_high(0);
        check("m0_miso_byte", {24'd0, r0}, 32'h3C);
        check("m0_rx_count", rx_cnt[0] - base_rx, 32'd1);
        check("m0_rx_hold", {24'd0, rx_byte_w[0]}, 32'hA5);
        check("m0_ready_back", {31'd0, ready_w[0]}, 32'd1);

        // Mode 3: two bytes back to back, second written while the first shifts.
        base_rx  = rx_cnt[3];
        base_und = und_cnt[3];
        write_hold(3, 8'hC1);
        pend_byte  = 8'hC2;
        pend_valid = 1'b1;
        cs_low(3);
        xfer(3, 8'h12, 8, r0);
        xfer(3, 8'h34, 8, r1);
        cs_high(3);
        check("m3_miso_byte0", {24'd0, r0}, 32'hC1);
        check("m3_miso_byte1", {24'd0, r1}, 32'hC2);
        check("m3_rx_count", rx_cnt[3] - base_rx, 32'd2);
        check("m3_underruns", und_cnt[3] - base_und, 32'd0);
        check("m3_pend_taken", {31'd0, pend_valid}, 32'd0);

        // Mode 1: nothing loaded, default byte and a single underrun.
        base_und = und_cnt[1];
        cs_low(1);
        xfer(1, 8'h5A, 8, r0);
        cs_high(1);
        check("m1_miso_default", {24'd0, r0}, 32'hFF);
        check("m1_underruns", und_cnt[1] - base_und, 32'd1);
        check("m1_rx_hold", {24'd0, rx_byte_w[1]}, 32'h5A);

        // Mode 2: aborted 5-bit frame is dropped, next frame is clean.
        base_rx = rx_cnt[2];
        cs_low(2);
        xfer(2, 8'hF0, 5, r0);
        cs_high(2);
        check("m2_partial_no_dv", rx_cnt[2] - base_rx, 32'd0);
        cs_low(2);
        xfer(2, 8'h81, 8, r0);
        cs_high(2);
        check("m2_rx_count", rx_cnt[2] - base_rx, 32'd1);
        check("m2_rx_hold", {24'd0, rx_byte_w[2]}, 32'h81);
        check("m2_miso_default", {24'd0, r0}, 32'hFF);

        // Mode 0: reset mid-byte with 8'h77 waiting in the holding register.
        write_hold(0, 8'h11);
        cs_low(0);
        pend_byte  = 8'h77;
        pend_valid = 1'b1;
        xfer(0, 8'hC3, 3, r0);
        check("rst_pending_full", {31'd0, ready_w[0]}, 32'd0);
        #2 i_Rst_L = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready_w[0]}, 32'd1);
        check("arst_rx_byte", {24'd0, rx_byte_w[0]}, 32'd0);
        check("arst_cs_active", {31'd0, cs_w[0]}, 32'd0);
        check("arst_miso_en", {31'd0, misoen_w[0]}, 32'd0);
        check("arst_miso", {31'd0, miso_w[0]}, 32'd1);
        check("arst_underrun", {31'd0, und_w[0]}, 32'd0);
        csn_s[0]  = 1'b1;
        sclk_s[0] = 1'b0;
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (4) tick(0);
        cs_low(0);
        xfer(0, 8'h69, 8, r0);
        cs_high(0);
        check("post_rst_miso", {24'd0, r0}, 32'hFF);
        check("post_rst_rx", {24'd0, rx_byte_w[0]}, 32'h69);

        // Mode 0: TX write lands in the very cycle of the CS-fall underrun load.
        base_und = und_cnt[0];
        csn_s[0] = 1'b0;
        tick(0);
        tick(0);
        tx_byte_s  = 8'hE7;
        tx_dv_s[0] = 1'b1;
        tick(0);
        half(0);
        xfer(0, 8'h0F, 8, r0);
        xfer(0, 8'hF0, 8, r1);
        cs_high(0);
        check("race_byte0", {24'd0, r0}, 32'hFF);
        check("race_byte1", {24'd0, r1}, 32'hE7);
        check("race_underruns", und_cnt[0] - base_und, 32'd2);
        check("race_ready", {31'd0, ready_w[0]}, 32'd1);

        check("sb_empty", rx_exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
